// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, state encoding and ALU one-hot constants
package proc_pkg;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_MOVE = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_MOD  = 4'd9;

  // alu_op bit order, MSB first: {xor, add, sub, and, or, div, mod}
  localparam logic [6:0] ALU_XOR  = 7'b1000000;
  localparam logic [6:0] ALU_ADD  = 7'b0100000;
  localparam logic [6:0] ALU_SUB  = 7'b0010000;
  localparam logic [6:0] ALU_AND  = 7'b0001000;
  localparam logic [6:0] ALU_OR   = 7'b0000100;
  localparam logic [6:0] ALU_DIV  = 7'b0000010;
  localparam logic [6:0] ALU_MOD  = 7'b0000001;
  localparam logic [6:0] ALU_NONE = 7'b0000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_ALU_A,
    S_ALU_G,
    S_ALU_WB,
    S_ERR
  } state_e;

  function automatic logic [6:0] func_alu_op(input logic [3:0] func);
    case (func)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_DIV:  return ALU_DIV;
      OP_MOD:  return ALU_MOD;
      default: return ALU_NONE;
    endcase
  endfunction

  function automatic state_e func_first_state(input logic [3:0] func);
    case (func)
      OP_LOAD: return S_LOAD;
      OP_MOVE: return S_MOVE;
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_DIV, OP_MOD: return S_ALU_A;
      default: return S_ERR;
    endcase
  endfunction

endpackage

// File: rtl/proc_reg_dec.sv
// rtl/proc_reg_dec.sv - register index to one-hot select decoder
module proc_reg_dec #(
  parameter  int NREG   = 8,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic [RSEL_W-1:0] idx_i,
  output logic [NREG-1:0]   onehot_o
);

  assign onehot_o = {{(NREG-1){1'b0}}, 1'b1} << idx_i;

endmodule

// File: rtl/proc_ctrl_fsm.sv
// rtl/proc_ctrl_fsm.sv - multi-cycle processor control FSM driving a single shared bus
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int RSEL_W = $clog2(NREG),
  localparam int IW     = 4 + RSEL_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IW-1:0]     code,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] d,
  output logic              data_out,
  output logic [NREG-1:0]   bus_en,
  output logic [NREG-1:0]   reg_en,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic [6:0]        alu_op
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [NREG-1:0] rx_oh, ry_oh;

  logic              busy_q, done_q, illegal_q, data_out_q, a_in_q, g_in_q, g_out_q;
  logic [NREG-1:0]   bus_en_q, reg_en_q;
  logic [6:0]        alu_op_q;

  logic              busy_d, done_d, illegal_d, data_out_d, a_in_d, g_in_d, g_out_d;
  logic [NREG-1:0]   bus_en_d, reg_en_d;
  logic [6:0]        alu_op_d;

  // Decoders look at the next instruction so the registered outputs line up with state_q.
  proc_reg_dec #(.NREG(NREG)) u_rx_dec (
    .idx_i    (ir_d[IW-5 -: RSEL_W]),
    .onehot_o (rx_oh)
  );

  proc_reg_dec #(.NREG(NREG)) u_ry_dec (
    .idx_i    (ir_d[IW-5-RSEL_W -: RSEL_W]),
    .onehot_o (ry_oh)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_d    = code;
          state_d = func_first_state(code[IW-1 -: 4]);
        end
      end
      S_ALU_A: state_d = S_ALU_G;
      S_ALU_G: state_d = S_ALU_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_LOAD) || (state_d == S_MOVE) ||
                 (state_d == S_ALU_WB) || (state_d == S_ERR);
    illegal_d  = (state_d == S_ERR);
    data_out_d = (state_d == S_LOAD);
    a_in_d     = (state_d == S_ALU_A);
    g_in_d     = (state_d == S_ALU_G);
    g_out_d    = (state_d == S_ALU_WB);
    bus_en_d   = '0;
    reg_en_d   = '0;
    alu_op_d   = ALU_NONE;
    case (state_d)
      S_LOAD:   reg_en_d = rx_oh;
      S_MOVE: begin
        bus_en_d = ry_oh;
        reg_en_d = rx_oh;
      end
      S_ALU_A: begin
        bus_en_d = rx_oh;
        alu_op_d = func_alu_op(ir_d[IW-1 -: 4]);
      end
      S_ALU_G: begin
        bus_en_d = ry_oh;
        alu_op_d = func_alu_op(ir_d[IW-1 -: 4]);
      end
      S_ALU_WB: begin
        reg_en_d = rx_oh;
        alu_op_d = func_alu_op(ir_d[IW-1 -: 4]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      data_out_q <= 1'b0;
      a_in_q     <= 1'b0;
      g_in_q     <= 1'b0;
      g_out_q    <= 1'b0;
      bus_en_q   <= '0;
      reg_en_q   <= '0;
      alu_op_q   <= ALU_NONE;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      data_out_q <= data_out_d;
      a_in_q     <= a_in_d;
      g_in_q     <= g_in_d;
      g_out_q    <= g_out_d;
      bus_en_q   <= bus_en_d;
      reg_en_q   <= reg_en_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign d        = ir_q[DATA_W-1:0];
  assign data_out = data_out_q;
  assign bus_en   = bus_en_q;
  assign reg_en   = reg_en_q;
  assign a_in     = a_in_q;
  assign g_in     = g_in_q;
  assign g_out    = g_out_q;
  assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb/tb_proc_ctrl_fsm.sv - table-driven bench for proc_ctrl_fsm
module tb_proc_ctrl_fsm;

  localparam logic [6:0] A_XOR = 7'b1000000;
  localparam logic [6:0] A_ADD = 7'b0100000;
  localparam logic [6:0] A_SUB = 7'b0010000;
  localparam logic [6:0] A_AND = 7'b0001000;
  localparam logic [6:0] A_OR  = 7'b0000100;
  localparam logic [6:0] A_DIV = 7'b0000010;
  localparam logic [6:0] A_MOD = 7'b0000001;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        data_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic [6:0]  alu_op;
    logic [7:0]  bus_en;
    logic [7:0]  reg_en;
    logic [15:0] d;
  } out_t;

  typedef struct {
    logic        rst;
    logic        st;
    logic [22:0] code;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [22:0] code;
  logic        busy, done, illegal, data_out, a_in, g_in, g_out;
  logic [15:0] d;
  logic [7:0]  bus_en, reg_en;
  logic [6:0]  alu_op;

  logic        start16;
  logic [39:0] code16;
  logic        busy16, done16, illegal16, data_out16, a_in16, g_in16, g_out16;
  logic [31:0] d16;
  logic [15:0] bus_en16, reg_en16;
  logic [6:0]  alu_op16;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t got;
  vec_t vecs[64];
  int   nvec;

  always #5 clk = ~clk;

  proc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .start(start), .code(code),
    .busy(busy), .done(done), .illegal(illegal), .d(d), .data_out(data_out),
    .bus_en(bus_en), .reg_en(reg_en), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .alu_op(alu_op)
  );

  proc_ctrl_fsm #(.DATA_W(32), .NREG(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .code(code16),
    .busy(busy16), .done(done16), .illegal(illegal16), .d(d16), .data_out(data_out16),
    .bus_en(bus_en16), .reg_en(reg_en16), .a_in(a_in16), .g_in(g_in16), .g_out(g_out16),
    .alu_op(alu_op16)
  );

  assign got = '{busy, done, illegal, data_out, a_in, g_in, g_out, alu_op, bus_en, reg_en, d};

  function automatic logic [22:0] mk(input logic [3:0] f, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic [12:0] imm);
    return {f, rx, ry, imm};
  endfunction

  function automatic out_t o(input logic b, input logic dn, input logic il, input logic dout,
                             input logic a, input logic g, input logic go, input logic [6:0] al,
                             input logic [7:0] be, input logic [7:0] re, input logic [15:0] dv);
    return '{b, dn, il, dout, a, g, go, al, be, re, dv};
  endfunction

  task automatic add_vec(input logic rst, input logic st, input logic [22:0] c, input out_t e);
    vecs[nvec] = '{rst, st, c, e};
    nvec++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] alu_tab[3:9];

  initial begin
    reset = 1'b1; start = 1'b0; code = '0;
    start16 = 1'b0; code16 = '0;
    nvec = 0;

    // reset beats start
    add_vec(1, 1, mk(4'd1, 3'd2, 3'd0, 13'h1234), o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h0000));
    // LOAD r2 <- 0x1234
    add_vec(0, 1, mk(4'd1, 3'd2, 3'd0, 13'h1234), o(1,1,0,1,0,0,0, 7'd0, 8'h00, 8'h04, 16'h1234));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h1234));
    // ADD r1, r5
    add_vec(0, 1, mk(4'd3, 3'd1, 3'd5, 13'h0ABC), o(1,0,0,0,1,0,0, A_ADD, 8'h02, 8'h00, 16'hAABC));
    add_vec(0, 0, '0,                             o(1,0,0,0,0,1,0, A_ADD, 8'h20, 8'h00, 16'hAABC));
    add_vec(0, 0, '0,                             o(1,1,0,0,0,0,1, A_ADD, 8'h00, 8'h02, 16'hAABC));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'hAABC));
    // func 0xC is illegal
    add_vec(0, 1, mk(4'hC, 3'd3, 3'd4, 13'h0000), o(1,1,1,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h8000));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h8000));
    // SUB aborted by reset in ALU_G
    add_vec(0, 1, mk(4'd4, 3'd6, 3'd7, 13'h0001), o(1,0,0,0,1,0,0, A_SUB, 8'h40, 8'h00, 16'hE001));
    add_vec(0, 0, '0,                             o(1,0,0,0,0,1,0, A_SUB, 8'h80, 8'h00, 16'hE001));
    add_vec(1, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h0000));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h0000));
    // start held high: MOVE, ignored SUB while busy, SUB accepted in IDLE, then LOAD
    add_vec(0, 1, mk(4'd2, 3'd3, 3'd6, 13'h0055), o(1,1,0,0,0,0,0, 7'd0, 8'h40, 8'h08, 16'hC055));
    add_vec(0, 1, mk(4'd4, 3'd0, 3'd1, 13'h0002), o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'hC055));
    add_vec(0, 1, mk(4'd4, 3'd0, 3'd1, 13'h0002), o(1,0,0,0,1,0,0, A_SUB, 8'h01, 8'h00, 16'h2002));
    add_vec(0, 1, mk(4'd1, 3'd7, 3'd0, 13'h00FF), o(1,0,0,0,0,1,0, A_SUB, 8'h02, 8'h00, 16'h2002));
    add_vec(0, 1, mk(4'd1, 3'd7, 3'd0, 13'h00FF), o(1,1,0,0,0,0,1, A_SUB, 8'h00, 8'h01, 16'h2002));
    add_vec(0, 1, mk(4'd1, 3'd7, 3'd0, 13'h00FF), o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h2002));
    add_vec(0, 1, mk(4'd1, 3'd7, 3'd0, 13'h00FF), o(1,1,0,1,0,0,0, 7'd0, 8'h00, 8'h80, 16'h00FF));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h00FF));
    // MOVE with rx == ry
    add_vec(0, 1, mk(4'd2, 3'd4, 3'd4, 13'h0000), o(1,1,0,0,0,0,0, 7'd0, 8'h10, 8'h10, 16'h8000));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h8000));
    // func 0 is illegal
    add_vec(0, 1, mk(4'd0, 3'd1, 3'd1, 13'h1FFF), o(1,1,1,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h3FFF));
    add_vec(0, 0, '0,                             o(0,0,0,0,0,0,0, 7'd0, 8'h00, 8'h00, 16'h3FFF));

    #2;
    for (int i = 0; i < nvec; i++) begin
      reset = vecs[i].rst;
      start = vecs[i].st;
      code  = vecs[i].code;
      tick();
      check($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].exp));
    end

    // every ALU func: op held for three cycles, done only on the third, zero once idle
    alu_tab[3] = A_ADD; alu_tab[4] = A_SUB; alu_tab[5] = A_XOR; alu_tab[6] = A_OR;
    alu_tab[7] = A_AND; alu_tab[8] = A_DIV; alu_tab[9] = A_MOD;
    for (int f = 3; f <= 9; f++) begin
      reset = 1'b0;
      start = 1'b1;
      code  = mk(4'(f), 3'd2, 3'd3, 13'h0000);
      tick();
      start = 1'b0;
      check($sformatf("alu%0d_a", f), {55'd0, done, alu_op, a_in}, {55'd0, 1'b0, alu_tab[f], 1'b1});
      tick();
      check($sformatf("alu%0d_g", f), {55'd0, done, alu_op, g_in}, {55'd0, 1'b0, alu_tab[f], 1'b1});
      tick();
      check($sformatf("alu%0d_wb", f), {55'd0, done, alu_op, g_out}, {55'd0, 1'b1, alu_tab[f], 1'b1});
      tick();
      check($sformatf("alu%0d_idle", f), {55'd0, busy, alu_op, done}, 64'd0);
    end

    // wide configuration: MOVE r15 <- r0
    check("w16_reset", {busy16, done16, bus_en16, reg_en16, d16[13:0]}, 64'd0);
    start16 = 1'b1;
    code16  = {4'd2, 4'd15, 4'd0, 28'h0000123};
    tick();
    start16 = 1'b0;
    check("w16_move", {30'd0, busy16, done16, bus_en16, reg_en16},
          {30'd0, 1'b1, 1'b1, 16'h0001, 16'h8000});
    check("w16_d", {32'd0, d16}, {32'd0, 32'h00000123});
    tick();
    check("w16_idle", {30'd0, busy16, done16, bus_en16, reg_en16}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bus and immediate-composite width.
REQ-002 SHALL have parameter NREG, default 8: register count, power of two, >= 2.
REQ-003 SHALL derive local RSEL_W = clog2(NREG) and IW = 4 + RSEL_W + DATA_W (default 23).
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: instruction valid; accepted only in IDLE.
REQ-007 SHALL have port code  input  IW: instruction {func[3:0], rx[RSEL_W], ry[RSEL_W], imm[DATA_W-RSEL_W]}, MSB first.
REQ-008 SHALL have port busy  output  1: high in every non-IDLE state.
REQ-009 SHALL have port done  output  1: one-cycle pulse in the final cycle of each instruction.
REQ-010 SHALL have port illegal  output  1: one-cycle pulse, coincident with done, for an unsupported func.
REQ-011 SHALL have port d  output  DATA_W: latched {ry, imm}, the immediate-load value.
REQ-012 SHALL have port data_out  output  1: drives d onto the bus.
REQ-013 SHALL have port bus_en  output  NREG: one-hot register-to-bus tristate enable.
REQ-014 SHALL have port reg_en  output  NREG: one-hot register write enable.
REQ-015 SHALL have port a_in, g_in, g_out  output  1 each: A-latch load, G-latch load, G-to-bus drive.
REQ-016 SHALL have port alu_op  output  7: one-hot {xor, add, sub, and, or, div, mod}.

Function
REQ-017 SHALL latch code into an internal instruction register on the edge where start=1 in IDLE; code is ignored at all other times.
REQ-018 SHALL ignore start while busy; no queueing.
REQ-019 SHALL decode func: 1 LOAD, 2 MOVE, 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND, 8 DIV, 9 MOD; 0 and 10-15 illegal.
REQ-020 SHALL implement states IDLE, LOAD, MOVE, ALU_A, ALU_G, ALU_WB, ERR, with Moore outputs decoded from state and latched instruction only.
REQ-021 SHALL transition: IDLE->LOAD/MOVE/ALU_A/ERR on accepted start per func; LOAD, MOVE, ALU_WB, ERR -> IDLE; ALU_A -> ALU_G -> ALU_WB.
REQ-022 SHALL in LOAD assert data_out=1 and reg_en=onehot(rx).
REQ-023 SHALL in MOVE assert bus_en=onehot(ry) and reg_en=onehot(rx).
REQ-024 SHALL in ALU_A assert bus_en=onehot(rx) and a_in=1.
REQ-025 SHALL in ALU_G assert bus_en=onehot(ry) and g_in=1.
REQ-026 SHALL in ALU_WB assert g_out=1 and reg_en=onehot(rx), with bus_en all zero.
REQ-027 SHALL hold alu_op at the func-selected one-hot value in ALU_A, ALU_G and ALU_WB, and at zero in all other states.
REQ-028 SHALL assert done in LOAD, MOVE, ALU_WB and ERR; latency from accepted start to done: 1 cycle for LOAD/MOVE/ERR, 3 cycles for ALU ops.
REQ-029 SHALL in ERR assert illegal=1 and done=1 with every enable zero.
REQ-030 SHALL keep bus_en at most one-hot and never assert data_out or g_out together with any bus_en bit (single bus driver).
REQ-031 SHALL allow rx==ry with no special case.
REQ-032 SHALL accept a new start in the IDLE cycle immediately after done (back-to-back issue).

Reset
REQ-033 SHALL on reset=1 at a clock edge enter IDLE and clear the instruction register, including mid-instruction.
REQ-034 SHALL drive all outputs to zero in the cycle after reset, with no done pulse for an aborted instruction.
REQ-035 SHALL give reset priority over start.

Structure
REQ-036 SHALL take opcode constants, the state enum and alu_op one-hot constants from shared package proc_pkg.
REQ-037 SHALL instantiate sub-module proc_reg_dec (parameter NREG; RSEL_W-bit index in, NREG-bit one-hot out, combinational) once each for rx and ry.

Verification
REQ-038 SHALL cover: start with code={1,r2,0x1234 composite} -> next cycle data_out=1, reg_en=0x04, d=0x1234, done=1; following cycle busy=0.
REQ-039 SHALL cover: ADD rx=1, ry=5 -> ALU_A bus_en=0x02 a_in=1; ALU_G bus_en=0x20 g_in=1; ALU_WB g_out=1 reg_en=0x02; alu_op=0b0100000 throughout; done on cycle 3.
REQ-040 SHALL cover: func=0xC -> one cycle with illegal=1, done=1, all enables 0; then IDLE.
REQ-041 SHALL cover: reset asserted during ALU_G -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-042 SHALL cover: start held high across MOVE then SUB -> second instruction accepted only in the IDLE cycle after MOVE done; start during busy ignored.
REQ-043 SHALL cover: NREG=16, DATA_W=32 -> MOVE rx=15, ry=0 gives bus_en=0x0001, reg_en=0x8000.
